imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the decode stage. Accepts an instruction word
//  plus format select over a valid/ready handshake, builds the sign/zero-extended XLEN-bit immediate,
//  and holds results in a 2-entry elastic output buffer. Adds CSR zimm, an illegal-format flag,
//  an optional tag and flush beyond the plain 32-bit extender.
// PARAMETERS
//  XLEN   32  immediate width; legal values 32 or 64
//  TAG_W  4   width of sideband tag carried with each immediate (>=1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  flush        in   1      synchronous clear of buffer contents
//  in_valid     in   1      input request valid
//  in_ready     out  1      block can accept this cycle
//  in_instr     in   32     instruction word (RVC uses [15:0])
//  in_imm_src   in   3      format select (see BEHAVIOUR)
//  in_tag       in   TAG_W  sideband tag, returned unchanged
//  in_is_rvc    in   1      compressed-format select; present only when IMM_RVC_EN defined
//  out_valid    out  1      head entry valid
//  out_ready    in   1      consumer accepts head entry
//  out_imm      out  XLEN   immediate
//  out_tag      out  TAG_W  tag of head entry
//  out_illegal  out  1      head entry used unsupported format (out_imm = 0)
// BEHAVIOUR
//  - Formats (S = in_instr[31], sign-extended to XLEN unless noted):
//    000 I {S.., [31:20]}; 001 S {S.., [31:25],[11:7]}; 010 B {S.., [7],[30:25],[11:8],0};
//    011 J {S.., [19:12],[20],[30:21],0}; 100 U {S.., [31:12], 12'h0} (sign-ext for XLEN=64);
//    101 shamt zero-ext: XLEN=32 [24:20], XLEN=64 [25:20]; 110 zimm zero-ext [19:15];
//    111 illegal: out_imm=0, out_illegal=1. All other formats out_illegal=0.
//  - Handshake: push = in_valid & in_ready; pop = out_valid & out_ready. in_ready = !rst & (count<2).
//  - Buffer: 2-entry FIFO, count 0..2; out_valid = (count!=0). Latency accept->out_valid: 1 cycle.
//    Push+pop same cycle: count unchanged, order preserved. Full (2): in_ready=0. Strict FIFO order.
//  - out_imm/out_tag/out_illegal stable while out_valid & !out_ready.
//  - flush: next cycle count=0, out_valid=0; a push in the flush cycle is dropped; in_ready=1 next cycle.
//  - Reset: count=0, out_valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=0 while rst high,
//    1 on first cycle after. Reset mid-stream discards all entries; rst has priority over flush.
//  - Immediate computed combinationally from inputs and written into buffer on push (no decode reg).
//  - XLEN other than 32/64: elaboration error.
// CONFIGURATION
//  IMM_RVC_EN defined: in_is_rvc port exists; when 1, in_imm_src selects RVC formats on in_instr[15:0]:
//    000 CI {sext [12],[6:2]}; 001 CJ {sext [12],[8],[10:9],[6],[7],[2],[11],[5:3],0};
//    010 CB {sext [12],[6:5],[2],[11:10],[4:3],0}; 011..111 illegal (out_imm=0, out_illegal=1).
//    When 0, decoding identical to base formats.
//  IMM_RVC_EN undefined: no in_is_rvc port; only base formats decoded.
// TESTING
//  1 I-type: instr 0xFFF00093, src 000, tag 3 -> next cycle out_valid=1, out_imm 0xFFFFFFFF, tag 3.
//  2 B-type: instr 0xFE000EE3, src 010 -> out_imm 0xFFFFFFFC; src 111 -> out_imm 0, out_illegal=1.
//  3 XLEN=64 U: instr 0x800002B7, src 100 -> 0xFFFFFFFF80000000; src 101 instr[25:20]=6'h3F -> 63.
//  4 Backpressure: out_ready=0, 3 pushes -> in_ready=0 after 2 accepted; release -> tags in order,
//    push+pop at count 1 keeps count 1.
//  5 Flush with in_valid=1 at count 2 -> next cycle out_valid=0, flushed-cycle input never emitted;
//    rst mid-stream -> all outputs 0, in_ready=0 during rst.
//  6 IMM_RVC_EN: in_is_rvc=1, instr 0x10FD, src 000 -> out_imm 0xFFFFFFFF; src 100 -> out_illegal=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator feeding a 2-entry elastic output FIFO.
// Compressed (RVC) formats and the in_is_rvc port are built only when IMM_RVC_EN is defined.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
`ifdef IMM_RVC_EN
    input  logic             in_is_rvc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("imm_gen_pipe: TAG_W must be at least 1");
        end
    endgenerate

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] base_imm(input logic [31:0] ins, input logic [2:0] src);
        logic s;
        s = ins[31];
        case (src)
            3'b000:  return sext32({{20{s}}, ins[31:20]});
            3'b001:  return sext32({{20{s}}, ins[31:25], ins[11:7]});
            3'b010:  return sext32({{19{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            3'b011:  return sext32({{11{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            3'b100:  return sext32({ins[31:12], 12'h000});
            // RV64 shift amounts carry one extra bit
            3'b101:  return (XLEN == 32) ? zext32({27'd0, ins[24:20]}) : zext32({26'd0, ins[25:20]});
            3'b110:  return zext32({27'd0, ins[19:15]});
            default: return '0;
        endcase
    endfunction

`ifdef IMM_RVC_EN
    function automatic logic [XLEN-1:0] rvc_imm(input logic [31:0] ins, input logic [2:0] src);
        logic s;
        s = ins[12];
        case (src)
            3'b000:  return sext32({{26{s}}, ins[12], ins[6:2]});
            3'b001:  return sext32({{20{s}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                                    ins[2], ins[11], ins[5:3], 1'b0});
            3'b010:  return sext32({{23{s}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0});
            default: return '0;
        endcase
    endfunction
`else
    logic unused_instr_s;
    assign unused_instr_s = ^in_instr[6:0];
`endif

    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_ill_s;
    logic             push_s;
    logic             pop_s;
    logic [1:0]       count_r;
    logic [XLEN-1:0]  imm0_r;
    logic [XLEN-1:0]  imm1_r;
    logic [TAG_W-1:0] tag0_r;
    logic [TAG_W-1:0] tag1_r;
    logic             ill0_r;
    logic             ill1_r;

    // Combinational decode of the incoming instruction; written into the FIFO on push.
    always_comb begin
        dec_imm_s = '0;
        dec_ill_s = 1'b0;
`ifdef IMM_RVC_EN
        if (in_is_rvc) begin
            dec_imm_s = rvc_imm(in_instr, in_imm_src);
            dec_ill_s = (in_imm_src > 3'b010);
        end else begin
            dec_imm_s = base_imm(in_instr, in_imm_src);
            dec_ill_s = (in_imm_src == 3'b111);
        end
`else
        dec_imm_s = base_imm(in_instr, in_imm_src);
        dec_ill_s = (in_imm_src == 3'b111);
`endif
    end

    assign in_ready    = !rst && (count_r < 2'd2);
    assign out_valid   = (count_r != 2'd0);
    assign push_s      = in_valid && in_ready;
    assign pop_s       = out_valid && out_ready;
    assign out_imm     = imm0_r;
    assign out_tag     = tag0_r;
    assign out_illegal = ill0_r;

    // Two-slot FIFO: slot 0 is always the head, slot 1 shifts down on pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_r <= 2'd0;
            imm0_r  <= '0;
            imm1_r  <= '0;
            tag0_r  <= '0;
            tag1_r  <= '0;
            ill0_r  <= 1'b0;
            ill1_r  <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        imm0_r <= dec_imm_s;
                        tag0_r <= in_tag;
                        ill0_r <= dec_ill_s;
                    end else begin
                        imm1_r <= dec_imm_s;
                        tag1_r <= in_tag;
                        ill1_r <= dec_ill_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    imm0_r  <= imm1_r;
                    tag0_r  <= tag1_r;
                    ill0_r  <= ill1_r;
                    count_r <= count_r - 2'd1;
                end
                // Simultaneous push and pop only happens with a single entry held
                2'b11: begin
                    imm0_r  <= dec_imm_s;
                    tag0_r  <= in_tag;
                    ill0_r  <= dec_ill_s;
                    count_r <= count_r;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are compared against an arithmetic reference model with a queue-based FIFO.
module tb_imm_gen_pipe;

    localparam int TAG_W = 4;

    typedef struct {
        logic [63:0]      e32;
        logic [63:0]      e64;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_instr = 32'd0;
    logic [2:0]       in_imm_src = 3'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_is_rvc = 1'b0;
    logic             out_ready = 1'b0;

    logic             in_ready32, in_ready64;
    logic             out_valid32, out_valid64;
    logic [31:0]      out_imm32;
    logic [63:0]      out_imm64;
    logic [TAG_W-1:0] out_tag32, out_tag64;
    logic             out_ill32, out_ill64;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   zero_head = 1'b0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
`ifdef IMM_RVC_EN
        .in_is_rvc(in_is_rvc),
`endif
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_tag(out_tag32), .out_illegal(out_ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
`ifdef IMM_RVC_EN
        .in_is_rvc(in_is_rvc),
`endif
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_tag(out_tag64), .out_illegal(out_ill64)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Interpret the low 'bits' of v as a two's-complement number.
    function automatic longint sx(input longint v, input int bits);
        if (v[bits-1]) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit rvc,
                                    input int xlen, output logic [63:0] imm, output logic ill);
        longint v;
        v = 0;
        ill = 1'b0;
        if (rvc) begin
            case (src)
                3'd0: v = sx(longint'(ins[12]) * 32 + longint'(ins[6:2]), 6);
                3'd1: v = sx(longint'(ins[12]) * 2048 + longint'(ins[8]) * 1024 +
                             longint'(ins[10:9]) * 256 + longint'(ins[6]) * 128 +
                             longint'(ins[7]) * 64 + longint'(ins[2]) * 32 +
                             longint'(ins[11]) * 16 + longint'(ins[5:3]) * 2, 12);
                3'd2: v = sx(longint'(ins[12]) * 256 + longint'(ins[6:5]) * 64 +
                             longint'(ins[2]) * 32 + longint'(ins[11:10]) * 8 +
                             longint'(ins[4:3]) * 2, 9);
                default: ill = 1'b1;
            endcase
        end else begin
            case (src)
                3'd0: v = sx(longint'(ins[31:20]), 12);
                3'd1: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
                3'd2: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                             longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
                3'd3: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                             longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
                3'd4: v = sx(longint'(ins[31:12]) * 4096, 32);
                3'd5: v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
                3'd6: v = longint'(ins[19:15]);
                default: ill = 1'b1;
            endcase
        end
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        imm = v;
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        logic l32, l64;
        ref_imm(in_instr, in_imm_src, in_is_rvc, 32, e.e32, l32);
        ref_imm(in_instr, in_imm_src, in_is_rvc, 64, e.e64, l64);
        e.tag = in_tag;
        e.ill = l32;
        return e;
    endfunction

    // One clock: compare DUT outputs against the model, then advance the model across the edge.
    task automatic step();
        bit push_b, pop_b;
        #1;
        check_val("in_ready32", 64'(in_ready32), 64'(!rst && q.size() < 2));
        check_val("in_ready64", 64'(in_ready64), 64'(!rst && q.size() < 2));
        check_val("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
        check_val("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("imm32", 64'(out_imm32), q[0].e32);
            check_val("imm64", out_imm64, q[0].e64);
            check_val("tag32", 64'(out_tag32), 64'(q[0].tag));
            check_val("tag64", 64'(out_tag64), 64'(q[0].tag));
            check_val("ill32", 64'(out_ill32), 64'(q[0].ill));
            check_val("ill64", 64'(out_ill64), 64'(q[0].ill));
        end else if (zero_head) begin
            check_val("rst_imm32", 64'(out_imm32), 64'd0);
            check_val("rst_imm64", out_imm64, 64'd0);
            check_val("rst_tag", 64'(out_tag32), 64'd0);
            check_val("rst_ill", 64'(out_ill32), 64'd0);
        end
        push_b = in_valid && !rst && (q.size() < 2);
        pop_b  = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            zero_head = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop_b) void'(q.pop_front());
            if (push_b) begin
                q.push_back(make_exp());
                zero_head = 1'b0;
            end
        end
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tg);
        in_valid = 1'b1;
        in_instr = ins;
        in_imm_src = src;
        in_tag = tg;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        zero_head = 1'b1;
        step();
        rst = 1'b0;
        step();

        push_one(32'hFFF0_0093, 3'b000, 4'd3);
        check_val("t1_valid", 64'(out_valid32), 64'd1);
        check_val("t1_imm", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
        check_val("t1_tag", 64'(out_tag32), 64'd3);
        drain();

        push_one(32'hFE00_0EE3, 3'b010, 4'd5);
        check_val("t2_bimm", 64'(out_imm32), 64'h0000_0000_FFFF_FFFC);
        drain();
        push_one(32'hFE00_0EE3, 3'b111, 4'd6);
        check_val("t2_illimm", 64'(out_imm32), 64'd0);
        check_val("t2_ill", 64'(out_ill32), 64'd1);
        drain();

        push_one(32'h8000_02B7, 3'b100, 4'd7);
        check_val("t3_u64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        check_val("t3_u32", 64'(out_imm32), 64'h0000_0000_8000_0000);
        drain();
        push_one(32'h03F0_0000, 3'b101, 4'd8);
        check_val("t3_sh64", out_imm64, 64'd63);
        check_val("t3_sh32", 64'(out_imm32), 64'd31);
        drain();

        // Backpressure: third push must be refused, then order and push+pop at count 1.
        in_valid = 1'b1;
        out_ready = 1'b0;
        in_imm_src = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            in_tag = 4'(i);
            in_instr = $urandom();
            step();
        end
        check_val("t4_full_ready", 64'(in_ready32), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_val("t4_head_tag", 64'(out_tag32), 64'd2);
        in_valid = 1'b1;
        in_tag = 4'd5;
        step();
        check_val("t4_pp_valid", 64'(out_valid32), 64'd1);
        check_val("t4_pp_tag", 64'(out_tag32), 64'd5);
        drain();

        // Flush at count 2 and at count 1, each with a push attempt in the flush cycle.
        push_one(32'h1234_5678, 3'b001, 4'd9);
        push_one(32'h8765_4321, 3'b011, 4'd10);
        in_valid = 1'b1;
        flush = 1'b1;
        in_tag = 4'd11;
        step();
        check_val("t5_flush2_valid", 64'(out_valid32), 64'd0);
        push_one(32'h0BAD_F00D, 3'b110, 4'd12);
        in_valid = 1'b1;
        flush = 1'b1;
        in_tag = 4'd13;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_val("t5_flush1_valid", 64'(out_valid32), 64'd0);
        step();

        // Reset mid-stream.
        push_one(32'hDEAD_BEEF, 3'b000, 4'd14);
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_val("t5_rst_ready", 64'(in_ready32), 64'd0);
        step();
        check_val("t5_rst_valid", 64'(out_valid32), 64'd0);
        check_val("t5_rst_imm", 64'(out_imm32), 64'd0);
        check_val("t5_rst_tag", 64'(out_tag32), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();

`ifdef IMM_RVC_EN
        in_is_rvc = 1'b1;
        push_one(32'h0000_10FD, 3'b000, 4'd1);
        check_val("t6_ci", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
        drain();
        push_one(32'h0000_10FD, 3'b100, 4'd2);
        check_val("t6_ill", 64'(out_ill32), 64'd1);
        drain();
        in_is_rvc = 1'b0;
`endif

        for (int n = 0; n < 3000; n++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            in_instr   = $urandom();
            in_imm_src = 3'($urandom_range(0, 7));
            in_tag     = TAG_W'($urandom());
            flush      = ($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 63) == 0);
`ifdef IMM_RVC_EN
            in_is_rvc  = $urandom_range(0, 1) == 1;
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
